// File: rtl/timer_pkg.sv
`default_nettype none
// ============================================================================
// timer_pkg
// Shared types and limits for the BCD MM:SS countdown timer.
// Rev 1.0
// ============================================================================
package timer_pkg;

    localparam int BCD_W  = 4;
    localparam int TIME_W = 4 * BCD_W;

    localparam logic [BCD_W-1:0] DIGIT_MAX    = 4'd9;
    localparam logic [BCD_W-1:0] SEC_TENS_MAX = 4'd5;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        RUN   = 2'd1,
        PAUSE = 2'd2,
        DONE  = 2'd3
    } state_t;

endpackage
`default_nettype wire

// File: rtl/countdown_timer_if.sv
`default_nettype none
// ============================================================================
// countdown_timer_if
// Command strobes and time/status outputs of the countdown timer.
// Rev 1.0
// ============================================================================
interface countdown_timer_if;
    import timer_pkg::*;

    logic              load;
    logic [TIME_W-1:0] load_bcd;
    logic              start;
    logic              pause;
    logic [TIME_W-1:0] time_bcd;
    logic              running;
    logic              done;
    logic              expired;

    modport master (
        output load, load_bcd, start, pause,
        input  time_bcd, running, done, expired
    );

    modport slave (
        input  load, load_bcd, start, pause,
        output time_bcd, running, done, expired
    );

endinterface
`default_nettype wire

// File: rtl/tick_divider.sv
`default_nettype none
// ============================================================================
// tick_divider
// Enable-gated modulo-TICK_DIV counter; tick is high in its last count.
// Rev 1.0
// ============================================================================
module tick_divider #(
    parameter int TICK_DIV = 25000000
) (
    input  logic clk,
    input  logic rst,
    input  logic en,
    input  logic clr,
    output logic tick
);

    localparam int               CNT_W    = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TICK_DIV - 1);

    logic [CNT_W-1:0] r_cnt;
    logic             w_at_last;

    assign w_at_last = (r_cnt == CNT_LAST);
    assign tick      = en & w_at_last;

    // Holding while disabled keeps the sub-second phase across a pause.
    always_ff @(posedge clk) begin
        if (!rst) begin
            r_cnt <= '0;
        end else if (clr) begin
            r_cnt <= '0;
        end else if (en) begin
            r_cnt <= w_at_last ? '0 : r_cnt + CNT_W'(1);
        end
    end

endmodule
`default_nettype wire

// File: rtl/countdown_timer.sv
`default_nettype none
// ============================================================================
// countdown_timer
// Loadable BCD MM:SS down-counter; define AUTO_RELOAD_EN to restart from the
// loaded value instead of stopping in DONE. Rev 1.0
// ============================================================================
module countdown_timer #(
    parameter int TICK_DIV = 25000000
) (
    input  logic               clk,
    input  logic               rst,
    countdown_timer_if.slave   tmr
);
    import timer_pkg::*;

    state_t            r_state;
    state_t            w_state_nxt;
    logic [TIME_W-1:0] r_time;
    logic [TIME_W-1:0] w_time_nxt;
    logic [TIME_W-1:0] w_dec;
    logic              r_running;
    logic              r_done;
    logic              r_expired;
    logic              w_expired_nxt;
    logic              w_tick;
    logic              w_div_en;
    logic              w_div_clr;
`ifdef AUTO_RELOAD_EN
    logic [TIME_W-1:0] r_reload;
    logic [TIME_W-1:0] w_reload_nxt;
`endif

    function automatic logic [TIME_W-1:0] sanitise(input logic [TIME_W-1:0] v);
        logic [TIME_W-1:0] r;
        logic [BCD_W-1:0]  lim;
        r = '0;
        for (int i = 0; i < 4; i++) begin
            lim = (i == 1) ? SEC_TENS_MAX : DIGIT_MAX;
            r[i*BCD_W +: BCD_W] = (v[i*BCD_W +: BCD_W] > lim) ? lim : v[i*BCD_W +: BCD_W];
        end
        return r;
    endfunction

    // Borrow ripples upward from sec_ones; sec_tens wraps to 5, others to 9.
    function automatic logic [TIME_W-1:0] bcd_dec(input logic [TIME_W-1:0] v);
        logic [TIME_W-1:0] r;
        logic              borrow;
        r      = v;
        borrow = 1'b1;
        for (int i = 0; i < 4; i++) begin
            if (borrow) begin
                if (v[i*BCD_W +: BCD_W] == '0) begin
                    r[i*BCD_W +: BCD_W] = (i == 1) ? SEC_TENS_MAX : DIGIT_MAX;
                end else begin
                    r[i*BCD_W +: BCD_W] = v[i*BCD_W +: BCD_W] - BCD_W'(1);
                    borrow              = 1'b0;
                end
            end
        end
        return r;
    endfunction

    assign w_div_en  = (r_state == RUN);
    assign w_div_clr = tmr.load;

    tick_divider #(
        .TICK_DIV (TICK_DIV)
    ) u_tick_divider (
        .clk  (clk),
        .rst  (rst),
        .en   (w_div_en),
        .clr  (w_div_clr),
        .tick (w_tick)
    );

    always_comb begin
        w_state_nxt   = r_state;
        w_time_nxt    = r_time;
        w_expired_nxt = 1'b0;
        w_dec         = bcd_dec(r_time);
`ifdef AUTO_RELOAD_EN
        w_reload_nxt  = r_reload;
`endif
        if (tmr.load) begin
            w_time_nxt  = sanitise(tmr.load_bcd);
            w_state_nxt = IDLE;
`ifdef AUTO_RELOAD_EN
            w_reload_nxt = sanitise(tmr.load_bcd);
`endif
        end else begin
            case (r_state)
                IDLE, PAUSE: begin
                    if (tmr.start && (r_time != '0)) begin
                        w_state_nxt = RUN;
                    end
                end
                RUN: begin
                    if (w_tick) begin
`ifdef AUTO_RELOAD_EN
                        // 0000 is held for one full tick before reloading.
                        if (r_time == '0) begin
                            w_time_nxt = r_reload;
                        end else begin
                            w_time_nxt    = w_dec;
                            w_expired_nxt = (w_dec == '0);
                        end
`else
                        w_time_nxt = w_dec;
                        if (w_dec == '0) begin
                            w_expired_nxt = 1'b1;
                            w_state_nxt   = DONE;
                        end
`endif
                    end
                    if (tmr.pause && (w_state_nxt == RUN)) begin
                        w_state_nxt = PAUSE;
                    end
                end
                default: begin
                end
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            r_state   <= IDLE;
            r_time    <= '0;
            r_running <= 1'b0;
            r_done    <= 1'b0;
            r_expired <= 1'b0;
        end else begin
            r_state   <= w_state_nxt;
            r_time    <= w_time_nxt;
            r_running <= (w_state_nxt == RUN);
            r_done    <= (w_state_nxt == DONE);
            r_expired <= w_expired_nxt;
        end
    end

`ifdef AUTO_RELOAD_EN
    always_ff @(posedge clk) begin
        if (!rst) begin
            r_reload <= '0;
        end else begin
            r_reload <= w_reload_nxt;
        end
    end
`endif

    assign tmr.time_bcd = r_time;
    assign tmr.running  = r_running;
    assign tmr.done     = r_done;
    assign tmr.expired  = r_expired;

endmodule
`default_nettype wire

// File: tb/tb_countdown_timer.sv
`default_nettype none
// ============================================================================
// tb_countdown_timer
// Directed stimulus with a seconds-based reference model checked every cycle.
// Rev 1.0
// ============================================================================
module tb_countdown_timer;

    localparam int TICK_DIV = 4;
    localparam int M_IDLE   = 0;
    localparam int M_RUN    = 1;
    localparam int M_PAUSE  = 2;
    localparam int M_DONE   = 3;

    logic clk = 1'b0;
    logic rst = 1'b0;

    int n_chk   = 0;
    int n_fail  = 0;
    int exp_cnt = 0;
    bit chk_en  = 1'b0;

    int m_secs   = 0;
    int m_reload = 0;
    int m_phase  = 0;
    int m_mode   = M_IDLE;
    bit m_exp    = 1'b0;

    countdown_timer_if tmr ();

    countdown_timer #(
        .TICK_DIV (TICK_DIV)
    ) dut (
        .clk (clk),
        .rst (rst),
        .tmr (tmr)
    );

    always #5 clk = ~clk;

    function automatic int min_i(input int a, input int b);
        return (a < b) ? a : b;
    endfunction

    function automatic int san_secs(input logic [15:0] v);
        int mt, mo, st, so;
        mt = min_i(int'(v[15:12]), 9);
        mo = min_i(int'(v[11:8]), 9);
        st = min_i(int'(v[7:4]), 5);
        so = min_i(int'(v[3:0]), 9);
        return (mt * 10 + mo) * 60 + st * 10 + so;
    endfunction

    function automatic logic [15:0] to_bcd(input int secs);
        int mm, ss;
        logic [15:0] r;
        mm = secs / 60;
        ss = secs % 60;
        r[15:12] = 4'(mm / 10);
        r[11:8]  = 4'(mm % 10);
        r[7:4]   = 4'(ss / 10);
        r[3:0]   = 4'(ss % 10);
        return r;
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    // Reference model: time kept as total seconds, tick every TICK_DIV running cycles.
    always @(posedge clk) begin : model
        int s, ph, md, rl;
        bit ex;
        s  = m_secs;
        ph = m_phase;
        md = m_mode;
        rl = m_reload;
        ex = 1'b0;
        if (!rst) begin
            s = 0; ph = 0; md = M_IDLE; rl = 0;
        end else if (tmr.load) begin
            s = san_secs(tmr.load_bcd); rl = s; ph = 0; md = M_IDLE;
        end else if (md == M_IDLE || md == M_PAUSE) begin
            if (tmr.start && s != 0) md = M_RUN;
        end else if (md == M_RUN) begin
            ph = ph + 1;
            if (ph == TICK_DIV) begin
                ph = 0;
                if (s == 0) begin
                    s = rl;
                end else begin
                    s = s - 1;
                    if (s == 0) begin
                        ex = 1'b1;
`ifndef AUTO_RELOAD_EN
                        md = M_DONE;
`endif
                    end
                end
            end
            if (tmr.pause && md == M_RUN) md = M_PAUSE;
        end
        m_secs   <= s;
        m_phase  <= ph;
        m_mode   <= md;
        m_reload <= rl;
        m_exp    <= ex;
    end

    always @(negedge clk) begin
        if (chk_en) begin
            check("time_bcd", 32'(tmr.time_bcd), 32'(to_bcd(m_secs)));
            check("running",  32'(tmr.running),  32'(m_mode == M_RUN));
            check("done",     32'(tmr.done),     32'(m_mode == M_DONE));
            check("expired",  32'(tmr.expired),  32'(m_exp));
            if (tmr.expired === 1'b1) exp_cnt++;
        end
    end

    task automatic pulse(input bit l, input bit s, input bit p, input logic [15:0] v);
        tmr.load_bcd = v;
        tmr.load     = l;
        tmr.start    = s;
        tmr.pause    = p;
        @(negedge clk);
        tmr.load  = 1'b0;
        tmr.start = 1'b0;
        tmr.pause = 1'b0;
    endtask

    task automatic wait_n(input int n);
        repeat (n) @(negedge clk);
    endtask

    initial begin : stim
        int base;
        tmr.load     = 1'b0;
        tmr.start    = 1'b0;
        tmr.pause    = 1'b0;
        tmr.load_bcd = 16'h0000;
        wait_n(2);
        check("rst_time",    32'(tmr.time_bcd), 32'h0000);
        check("rst_running", 32'(tmr.running),  32'h0);
        check("rst_done",    32'(tmr.done),     32'h0);
        check("rst_expired", 32'(tmr.expired),  32'h0);
        chk_en = 1'b1;
        rst    = 1'b1;
        wait_n(1);

`ifndef AUTO_RELOAD_EN
        // 0003 counts down with a tick every 4 cycles, then stops in DONE.
        pulse(1, 0, 0, 16'h0003);
        check("load_0003", 32'(tmr.time_bcd), 32'h0003);
        base = exp_cnt;
        pulse(0, 1, 0, 16'h0000);
        wait_n(3);  check("pre_tick",  32'(tmr.time_bcd), 32'h0003);
        wait_n(1);  check("tick1",     32'(tmr.time_bcd), 32'h0002);
        wait_n(4);  check("tick2",     32'(tmr.time_bcd), 32'h0001);
        wait_n(4);  check("tick3",     32'(tmr.time_bcd), 32'h0000);
        check("exp_pulse", 32'(tmr.expired), 32'h1);
        check("done_set",  32'(tmr.done),    32'h1);
        check("run_clr",   32'(tmr.running), 32'h0);
        wait_n(1);
        check("exp_once",  32'(exp_cnt - base), 32'h1);
        check("done_hold", 32'(tmr.done),    32'h1);
        pulse(0, 1, 0, 16'h0000);
        check("start_in_done", 32'(tmr.done), 32'h1);
`endif

        pulse(1, 0, 0, 16'h1000);
        pulse(0, 1, 0, 16'h0000);
        wait_n(4);  check("borrow_1000", 32'(tmr.time_bcd), 32'h0959);
        pulse(1, 0, 0, 16'h0100);
        pulse(0, 1, 0, 16'h0000);
        wait_n(4);  check("borrow_0100", 32'(tmr.time_bcd), 32'h0059);

        // Pause with the divider parked at 2; the next tick lands 2 cycles after resume.
        pulse(1, 0, 0, 16'h0005);
        pulse(0, 1, 0, 16'h0000);
        wait_n(1);
        pulse(0, 0, 1, 16'h0000);
        wait_n(20);
        check("pause_hold", 32'(tmr.time_bcd), 32'h0005);
        check("pause_run",  32'(tmr.running),  32'h0);
        pulse(0, 1, 0, 16'h0000);
        wait_n(1);  check("resume_pre",  32'(tmr.time_bcd), 32'h0005);
        wait_n(1);  check("resume_tick", 32'(tmr.time_bcd), 32'h0004);
        pulse(0, 1, 1, 16'h0000);
        check("both_in_run", 32'(tmr.running), 32'h0);

        pulse(1, 0, 0, 16'h9F7A);
        check("clamp_9F7A", 32'(tmr.time_bcd), 32'h9959);
        pulse(1, 0, 0, 16'h0A6B);
        check("clamp_0A6B", 32'(tmr.time_bcd), 32'h0959);
        pulse(1, 0, 0, 16'h0000);
        pulse(0, 1, 0, 16'h0000);
        check("start_zero", 32'(tmr.running), 32'h0);

`ifndef AUTO_RELOAD_EN
        pulse(1, 0, 0, 16'h0001);
        pulse(0, 1, 0, 16'h0000);
        wait_n(4);  check("done_0001", 32'(tmr.done), 32'h1);
        pulse(1, 0, 0, 16'h0042);
        check("load_in_done", 32'(tmr.done),     32'h0);
        check("load_time",    32'(tmr.time_bcd), 32'h0042);
`else
        // Auto reload: 0000 is shown for one tick, then the loaded value returns.
        pulse(1, 0, 0, 16'h0002);
        pulse(0, 1, 0, 16'h0000);
        wait_n(4);  check("ar_tick1", 32'(tmr.time_bcd), 32'h0001);
        wait_n(4);  check("ar_zero",  32'(tmr.time_bcd), 32'h0000);
        check("ar_exp",  32'(tmr.expired), 32'h1);
        check("ar_run",  32'(tmr.running), 32'h1);
        check("ar_done", 32'(tmr.done),    32'h0);
        wait_n(1);  check("ar_exp_clr", 32'(tmr.expired), 32'h0);
        wait_n(3);  check("ar_reload",  32'(tmr.time_bcd), 32'h0002);
        wait_n(4);  check("ar_tick2",   32'(tmr.time_bcd), 32'h0001);
        check("ar_run2", 32'(tmr.running), 32'h1);
`endif

        // Reset in the middle of a run: everything clears, no expired pulse.
        pulse(1, 0, 0, 16'h0002);
        pulse(0, 1, 0, 16'h0000);
        wait_n(2);
        base = exp_cnt;
        rst  = 1'b0;
        wait_n(1);
        check("mid_rst_time",    32'(tmr.time_bcd), 32'h0000);
        check("mid_rst_running", 32'(tmr.running),  32'h0);
        check("mid_rst_done",    32'(tmr.done),     32'h0);
        check("mid_rst_expired", 32'(tmr.expired),  32'h0);
        rst = 1'b1;
        wait_n(8);
        check("mid_rst_no_exp", 32'(exp_cnt - base), 32'h0);
        check("mid_rst_idle",   32'(tmr.time_bcd),   32'h0000);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/countdown_timer.md
Name: countdown_timer

Overview:
Loadable BCD MM:SS down-counter for the stopwatch/timer project. It counts in the opposite direction to the existing free-running up-counter. An internal clock divider generates one-second ticks that decrement the time value. The keyboard command decoder drives load/start/pause, and the 7-segment display path reads time_bcd.

Parameters:
TICK_DIV, 25000000, clk cycles per decrement tick (legal values >= 2)

Ports:
clk  input  1  system clock, single clock domain
rst  input  1  synchronous reset, active-low (0 = reset, sampled on posedge clk)
load  input  1  one-cycle strobe: capture load_bcd, go to IDLE
load_bcd  input  16  BCD value {min_tens, min_ones, sec_tens, sec_ones}
start  input  1  one-cycle strobe: begin or resume counting
pause  input  1  one-cycle strobe: hold counting
time_bcd  output  16  current BCD time value
running  output  1  1 while in RUN
done  output  1  level, 1 while in DONE
expired  output  1  one-cycle pulse when time_bcd reaches 0000 from RUN

Behaviour:
- Reset (rst==0 at posedge): state=IDLE, time_bcd=0000, reload register=0000, divider=0. All outputs 0.
- States and outputs:
  - IDLE: idle, all flags 0.
  - RUN: running=1.
  - PAUSE: running=0.
  - DONE: done=1.
- Priority, highest first: rst, then load, then start/pause.
- load, in any state: time_bcd <= sanitised load_bcd on the next edge. The reload register gets the same value. Divider is cleared. State goes to IDLE.
- Sanitising load_bcd, applied per digit:
  - Any BCD digit > 9 is clamped to 9.
  - sec_tens > 5 is clamped to 5.
- start:
  - IDLE or PAUSE with time_bcd != 0000: go to RUN.
  - IDLE or PAUSE with time_bcd == 0000: ignored.
  - RUN or DONE: ignored.
- pause: RUN goes to PAUSE. Ignored in all other states.
- start and pause in the same cycle: resolved by state. In RUN, pause wins. In IDLE/PAUSE, start wins.
- Divider:
  - Counts only in RUN, range 0..TICK_DIV-1.
  - Holds its value in PAUSE, so the sub-second phase is preserved across a resume.
  - tick fires in the cycle where divider == TICK_DIV-1; divider then wraps to 0.
  - The first tick after start therefore comes TICK_DIV cycles later.
- Decrement on tick, BCD borrow chain:
  - sec_ones 0 -> 9 with borrow.
  - sec_tens 0 -> 5 with borrow.
  - min_ones 0 -> 9 with borrow.
  - min_tens decrements.
  - Example: 10:00 -> 09:59.
- Tick that produces 0000: time_bcd=0000 and state=DONE on the same edge. expired=1 for exactly that next cycle. done stays 1 until load or rst.
- Reset mid-RUN: everything returns to reset values immediately. No expired pulse is generated.
- All outputs are registered. Latency from a strobe to the state/output change is one clock.

Optional Feature:
AUTO_RELOAD_EN
- Defined:
  - The tick reaching 0000 pulses expired and keeps state=RUN; done never asserts.
  - On the next tick, time_bcd <= reload register and counting continues.
  - 0000 is therefore visible for one full tick period.
  - pause/load behave as normal.
- Undefined: DONE behaviour as specified above.

Decomposition:
- Package timer_pkg:
  - State encoding enum: IDLE, RUN, PAUSE, DONE.
  - BCD digit width constant (4).
  - Limits SEC_TENS_MAX=5 and DIGIT_MAX=9.
- One natural sub-module: tick_divider.
  - Inputs: clk, rst, en, clr.
  - Output: tick.
  - Parameter: TICK_DIV.
- BCD decrement and sanitise logic stay in the top module as functions.

Test Plan:
- TICK_DIV=4. Reset then load 0003, start -> time 0002/0001/0000 at cycles 4/8/12 after start. expired pulses exactly once; done=1 and running=0 afterwards.
- Load 1000, start, 1 tick -> time_bcd=0959. Load 0100, 1 tick -> 0059 (full borrow chain).
- Load 0005, start, pause at divider=2, wait 20 cycles, start -> value unchanged during the pause. Next tick arrives 2 cycles after resume.
- Load 9F7A -> time_bcd=9959 (clamping). Load 0000 then start -> stays IDLE, running=0.
- Start and pause asserted together in RUN -> PAUSE. Load during DONE -> IDLE, done=0. rst=0 mid-RUN -> all outputs 0 next cycle, no expired pulse.
- AUTO_RELOAD_EN, load 0002, start -> 0001, 0000 (expired), 0002, 0001 ... running stays 1 and done stays 0.
